// File: rtl/etc_pkg.sv
// Shared definitions for the semiring tile engine: op encoding and
// per-op reduction identity.
package etc_pkg;

    localparam int OP_W  = 3;
    localparam int MAX_W = 64;

    typedef enum logic [OP_W-1:0] {
        OP_PLUS_TIMES = 3'd0,
        OP_MAX_PLUS   = 3'd1,
        OP_MIN_PLUS   = 3'd2,
        OP_MAX_MIN    = 3'd3,
        OP_MIN_MAX    = 3'd4,
        OP_OR_AND     = 3'd5
    } opT;

    function automatic logic isReservedOp(input logic [OP_W-1:0] op);
        return op > OP_OR_AND;
    endfunction

    // Identity at the widest supported element width; callers truncate to W.
    function automatic logic [MAX_W-1:0] opIdentity(input logic [OP_W-1:0] op);
        case (op)
            OP_MIN_PLUS, OP_MIN_MAX: return '1;
            default:                 return '0;
        endcase
    endfunction

endpackage

// File: rtl/etc_semiring_pe.sv
// One result element: N element-wise combines into a register, then a
// reduction tree plus accumulate into the element's output register.
module etc_semiring_pe
    import etc_pkg::*;
#(
    parameter int W = 16,
    parameter int N = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                combineEn,
    input  logic [OP_W-1:0]     combineOp,
    input  logic [N-1:0][W-1:0] aRow,
    input  logic [N-1:0][W-1:0] bCol,
    input  logic                reduceEn,
    input  logic [OP_W-1:0]     reduceOp,
    input  logic                reduceAcc,
    input  logic [W-1:0]        reduceC,
    output logic [W-1:0]        d
);

    localparam int LEAVES = 1 << $clog2(N);

    function automatic logic [W-1:0] combine(input logic [OP_W-1:0] op,
                                             input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        logic [W-1:0] prod;
        logic [W:0]   sum;
        prod = a * b;
        sum  = {1'b0, a} + {1'b0, b};
        case (op)
            OP_PLUS_TIMES:            return prod;
            OP_MAX_PLUS, OP_MIN_PLUS: return sum[W] ? '1 : sum[W-1:0];
            OP_MAX_MIN:               return (a < b) ? a : b;
            OP_MIN_MAX:               return (a > b) ? a : b;
            OP_OR_AND:                return a & b;
            default:                  return '0;
        endcase
    endfunction

    // Reserved ops collapse to zero here, which zeroes the whole result.
    function automatic logic [W-1:0] reduce(input logic [OP_W-1:0] op,
                                            input logic [W-1:0] x,
                                            input logic [W-1:0] y);
        case (op)
            OP_PLUS_TIMES:           return x + y;
            OP_MAX_PLUS, OP_MAX_MIN: return (x > y) ? x : y;
            OP_MIN_PLUS, OP_MIN_MAX: return (x < y) ? x : y;
            OP_OR_AND:               return x | y;
            default:                 return '0;
        endcase
    endfunction

    genvar gi;

    logic [N-1:0][W-1:0] prodNext;
    logic [N-1:0][W-1:0] prodReg;
    logic [W-1:0]        ident;
    logic [W-1:0]        node [1:2*LEAVES-1];
    logic [W-1:0]        dReg;
    logic [W-1:0]        dNext;

    for (gi = 0; gi < N; gi++) begin : gCombine
        assign prodNext[gi] = combine(combineOp, aRow[gi], bCol[gi]);
    end

    // Product register is only consumed when its stage is valid.
    always_ff @(posedge clk) begin
        if (combineEn) prodReg <= prodNext;
    end

    assign ident = W'(opIdentity(reduceOp));

    // Leaves beyond N are padded with the identity so any N fits the tree.
    for (gi = 0; gi < LEAVES; gi++) begin : gLeaf
        if (gi < N) begin : gReal
            assign node[LEAVES+gi] = prodReg[gi];
        end else begin : gPad
            assign node[LEAVES+gi] = ident;
        end
    end

    for (gi = 1; gi < LEAVES; gi++) begin : gTree
        assign node[gi] = reduce(reduceOp, node[2*gi], node[2*gi+1]);
    end

    assign dNext = reduce(reduceOp, reduceAcc ? reduceC : ident, node[1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        dReg <= '0;
        else if (reduceEn) dReg <= dNext;
    end

    assign d = dReg;

endmodule

// File: rtl/etc_semiring_mma.sv
// Three-stage N x N semiring matrix multiply-accumulate with a
// valid/ready handshake on both sides.
module etc_semiring_mma
    import etc_pkg::*;
#(
    parameter int W = 16,
    parameter int N = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [2:0]                 op,
    input  logic                       acc,
    input  logic [N-1:0][N-1:0][W-1:0] inA,
    input  logic [N-1:0][N-1:0][W-1:0] inB,
    input  logic [N-1:0][N-1:0][W-1:0] inC,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [N-1:0][N-1:0][W-1:0] out,
    output logic                       op_err,
    output logic [31:0]                tile_count
);

    genvar gi, gj, gk;

    logic                       s1Valid, s2Valid, s3Valid;
    logic [OP_W-1:0]            s1Op, s2Op;
    logic                       s1Acc, s2Acc;
    logic [N-1:0][N-1:0][W-1:0] s1A, s1B, s1C, s2C;
    logic                       opErrReg;
    logic [31:0]                tileCountReg;
    logic                       s1Ready, s2Ready, s3Ready;
    logic                       s1Load, s2Load, s3Load;

    // A stage can take new data when empty or when it is handing off.
    assign s3Ready = !s3Valid || out_ready;
    assign s2Ready = !s2Valid || s3Ready;
    assign s1Ready = !s1Valid || s2Ready;
    assign s1Load  = in_valid && s1Ready;
    assign s2Load  = s1Valid && s2Ready;
    assign s3Load  = s2Valid && s3Ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1Valid      <= 1'b0;
            s2Valid      <= 1'b0;
            s3Valid      <= 1'b0;
            opErrReg     <= 1'b0;
            tileCountReg <= '0;
        end else begin
            if (s1Ready) s1Valid <= in_valid;
            if (s2Ready) s2Valid <= s1Valid;
            if (s3Ready) s3Valid <= s2Valid;
            if (s3Load)  opErrReg <= isReservedOp(s2Op);
            if (s3Valid && out_ready) tileCountReg <= tileCountReg + 32'd1;
        end
    end

    // Operand and sideband registers are qualified by the stage valid bits.
    always_ff @(posedge clk) begin
        if (s1Load) begin
            s1A   <= inA;
            s1B   <= inB;
            s1C   <= inC;
            s1Op  <= op;
            s1Acc <= acc;
        end
        if (s2Load) begin
            s2C   <= s1C;
            s2Op  <= s1Op;
            s2Acc <= s1Acc;
        end
    end

    for (gi = 0; gi < N; gi++) begin : gRow
        for (gj = 0; gj < N; gj++) begin : gCol
            logic [N-1:0][W-1:0] bCol;
            for (gk = 0; gk < N; gk++) begin : gK
                assign bCol[gk] = s1B[gk][gj];
            end

            etc_semiring_pe #(
                .W (W),
                .N (N)
            ) uPe (
                .clk       (clk),
                .rst_n     (rst_n),
                .combineEn (s2Load),
                .combineOp (s1Op),
                .aRow      (s1A[gi]),
                .bCol      (bCol),
                .reduceEn  (s3Load),
                .reduceOp  (s2Op),
                .reduceAcc (s2Acc),
                .reduceC   (s2C[gi][gj]),
                .d         (out[gi][gj])
            );
        end
    end

    assign in_ready   = s1Ready;
    assign out_valid  = s3Valid;
    assign op_err     = opErrReg;
    assign tile_count = tileCountReg;

endmodule
